// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared board geometry, command opcodes and cursor FSM states
package game_pkg;

  localparam int ROWS   = 16;
  localparam int COLS   = 16;
  localparam int ROW_W  = 4;
  localparam int COL_W  = 4;
  localparam int ADDR_W = 8;

  localparam logic OP_REVEAL = 1'b0;
  localparam logic OP_FLAG   = 1'b1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/cursor_ctrl_if.sv
// rtl/cursor_ctrl_if.sv - board command handshake between cursor control and board-state logic
interface cursor_ctrl_if #(
  parameter int ADDR_W = game_pkg::ADDR_W
) ();

  logic              cmd_valid;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_addr,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_addr,
    output cmd_ready
  );

endinterface

// File: rtl/cursor_ctrl_wrap_counter.sv
// rtl/cursor_ctrl_wrap_counter.sv - modulus-N up/down index with wrap-around and inc/dec cancellation
module wrap_counter #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] idx
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  // Simultaneous inc and dec cancel, so only an exclusive request moves the index.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx <= '0;
    end else if (en && (inc != dec)) begin
      if (inc) begin
        idx <= (idx == LAST) ? '0 : idx + W'(1);
      end else begin
        idx <= (idx == '0) ? LAST : idx - W'(1);
      end
    end
  end

endmodule

// File: rtl/cursor_ctrl.sv
// rtl/cursor_ctrl.sv - minesweeper cursor position and reveal/flag command issue
module cursor_ctrl
  import game_pkg::*;
#(
  parameter int ROWS   = game_pkg::ROWS,
  parameter int COLS   = game_pkg::COLS,
  parameter int ROW_W  = game_pkg::ROW_W,
  parameter int COL_W  = game_pkg::COL_W,
  parameter int ADDR_W = game_pkg::ADDR_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             game_active,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_center,
  input  logic             flag_mode,
  output logic [ROW_W-1:0] cursor_row,
  output logic [COL_W-1:0] cursor_col,
  cursor_ctrl_if.master    cmd,
  output logic             cmd_dropped
);

  state_t            state, state_nx;
  logic              op_q;
  logic [ADDR_W-1:0] addr_q;
  logic              dropped_q;
  logic              press;
  logic              load;
  logic              drop;
  logic [ADDR_W-1:0] press_addr;

  wrap_counter #(.N(ROWS), .W(ROW_W)) u_row (
    .clock (clock),
    .reset (reset),
    .en    (game_active),
    .inc   (btn_down),
    .dec   (btn_up),
    .idx   (cursor_row)
  );

  wrap_counter #(.N(COLS), .W(COL_W)) u_col (
    .clock (clock),
    .reset (reset),
    .en    (game_active),
    .inc   (btn_right),
    .dec   (btn_left),
    .idx   (cursor_col)
  );

  assign press = btn_center & game_active;

  // Registered cursor is still the pre-move position during the press cycle.
  assign press_addr = ADDR_W'(cursor_row) * ADDR_W'(COLS) + ADDR_W'(cursor_col);

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    drop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (press) begin
          load     = 1'b1;
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (press) begin
          drop = 1'b1;
        end
        if (cmd.cmd_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= OP_REVEAL;
      addr_q    <= '0;
      dropped_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        op_q   <= flag_mode ? OP_FLAG : OP_REVEAL;
        addr_q <= press_addr;
      end
      if (drop) begin
        dropped_q <= 1'b1;
      end
    end
  end

  assign cmd.cmd_valid = (state == S_ISSUE);
  assign cmd.cmd_op    = op_q;
  assign cmd.cmd_addr  = addr_q;
  assign cmd_dropped   = dropped_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// tb/tb_cursor_ctrl.sv - directed self-checking bench for cursor_ctrl
module tb_cursor_ctrl;

  logic       clock;
  logic       reset;
  logic       game_active;
  logic       btn_up, btn_down, btn_left, btn_right, btn_center;
  logic       flag_mode;
  logic [3:0] cursor_row;
  logic [3:0] cursor_col;
  logic       cmd_dropped;
  int         checks;
  int         errors;

  cursor_ctrl_if #(.ADDR_W(8)) cmd_bus ();

  cursor_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .game_active (game_active),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_center  (btn_center),
    .flag_mode   (flag_mode),
    .cursor_row  (cursor_row),
    .cursor_col  (cursor_col),
    .cmd         (cmd_bus),
    .cmd_dropped (cmd_dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, return at the following negedge with inputs released.
  task automatic step(input logic up, input logic down, input logic left, input logic right,
                      input logic center, input logic flag);
    btn_up     = up;
    btn_down   = down;
    btn_left   = left;
    btn_right  = right;
    btn_center = center;
    flag_mode  = flag;
    @(negedge clock);
    btn_up     = 1'b0;
    btn_down   = 1'b0;
    btn_left   = 1'b0;
    btn_right  = 1'b0;
    btn_center = 1'b0;
    flag_mode  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_row"}, 32'(cursor_row), 0);
    check({tag, "_col"}, 32'(cursor_col), 0);
    check({tag, "_valid"}, 32'(cmd_bus.cmd_valid), 0);
    check({tag, "_op"}, 32'(cmd_bus.cmd_op), 0);
    check({tag, "_addr"}, 32'(cmd_bus.cmd_addr), 0);
    check({tag, "_dropped"}, 32'(cmd_dropped), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    game_active = 1'b1;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_center = 0; flag_mode = 0;
    cmd_bus.cmd_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_zero("reset");

    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0, 0);
    check("move_row", 32'(cursor_row), 2);
    check("move_col", 32'(cursor_col), 3);
    step(0, 0, 0, 0, 1, 0);
    check("reveal_valid", 32'(cmd_bus.cmd_valid), 1);
    check("reveal_op", 32'(cmd_bus.cmd_op), 0);
    check("reveal_addr", 32'(cmd_bus.cmd_addr), 35);
    cmd_bus.cmd_ready = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    cmd_bus.cmd_ready = 1'b0;
    check("reveal_accept", 32'(cmd_bus.cmd_valid), 0);

    do_reset();
    step(1, 0, 0, 0, 0, 0);
    check("wrap_up_row", 32'(cursor_row), 15);
    step(0, 0, 1, 0, 0, 0);
    check("wrap_left_col", 32'(cursor_col), 15);
    step(0, 1, 0, 1, 0, 0);
    check("wrap_diag_row", 32'(cursor_row), 0);
    check("wrap_diag_col", 32'(cursor_col), 0);

    for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 0, 0);
    check("diag5_row", 32'(cursor_row), 5);
    check("diag5_col", 32'(cursor_col), 5);
    step(1, 1, 0, 1, 0, 0);
    check("cancel_row", 32'(cursor_row), 5);
    check("cancel_col", 32'(cursor_col), 6);
    step(0, 0, 1, 1, 0, 0);
    check("cancel_lr_col", 32'(cursor_col), 6);

    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1);
    check("flag_valid", 32'(cmd_bus.cmd_valid), 1);
    check("flag_op", 32'(cmd_bus.cmd_op), 1);
    check("flag_addr", 32'(cmd_bus.cmd_addr), 35);
    check("flag_col", 32'(cursor_col), 4);

    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, (i == 4), 0);
      check("hold_valid", 32'(cmd_bus.cmd_valid), 1);
      check("hold_op", 32'(cmd_bus.cmd_op), 1);
      check("hold_addr", 32'(cmd_bus.cmd_addr), 35);
    end
    check("dropped_set", 32'(cmd_dropped), 1);
    cmd_bus.cmd_ready = 1'b1;
    step(0, 0, 0, 0, 1, 0);
    cmd_bus.cmd_ready = 1'b0;
    check("accept_valid", 32'(cmd_bus.cmd_valid), 0);
    step(0, 0, 0, 0, 0, 0);
    check("no_reissue", 32'(cmd_bus.cmd_valid), 0);
    check("dropped_sticky", 32'(cmd_dropped), 1);

    game_active = 1'b0;
    step(1, 1, 1, 1, 1, 1);
    step(1, 0, 1, 0, 1, 0);
    check("inactive_row", 32'(cursor_row), 2);
    check("inactive_col", 32'(cursor_col), 4);
    check("inactive_valid", 32'(cmd_bus.cmd_valid), 0);

    game_active = 1'b1;
    step(0, 0, 0, 0, 1, 0);
    check("issue2_valid", 32'(cmd_bus.cmd_valid), 1);
    check("issue2_addr", 32'(cmd_bus.cmd_addr), 36);
    check("issue2_op", 32'(cmd_bus.cmd_op), 0);
    game_active = 1'b0;
    cmd_bus.cmd_ready = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    cmd_bus.cmd_ready = 1'b0;
    check("inactive_complete", 32'(cmd_bus.cmd_valid), 0);

    game_active = 1'b1;
    step(0, 0, 0, 0, 1, 1);
    check("issue3_valid", 32'(cmd_bus.cmd_valid), 1);
    check("issue3_op", 32'(cmd_bus.cmd_op), 1);
    do_reset();
    check_zero("midreset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
